// File: rtl/jam_cost_arbiter.sv
// Round-robin arbiter sharing one synchronous job-cost memory between two search engines.
// Grants are held for up to BURST_LEN accepted reads so a permutation's lookups stay contiguous.
module jam_cost_arbiter #(
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned CW        = 7
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          req0,
    input  logic          req1,
    input  logic [2:0]    W0,
    input  logic [2:0]    W1,
    input  logic [2:0]    J0,
    input  logic [2:0]    J1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [CW-1:0] Cost0,
    output logic [CW-1:0] Cost1,
    output logic          cvld0,
    output logic          cvld1,
    output logic          mem_en,
    output logic [2:0]    mem_W,
    output logic [2:0]    mem_J,
    input  logic [CW-1:0] mem_Cost
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    localparam logic [2:0] BEAT_MAX = 3'(BURST_LEN - 1);

    state_t     state, state_nxt;
    logic [2:0] beat, beat_nxt;
    logic       last, last_nxt;
    logic       beat0, beat1, burst_end;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            beat  <= '0;
            last  <= 1'b1;
            cvld0 <= 1'b0;
            cvld1 <= 1'b0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            last  <= last_nxt;
            cvld0 <= beat0;
            cvld1 <= beat1;
        end
    end

    always_comb begin
        beat0     = (state == GNT0) && req0;
        beat1     = (state == GNT1) && req1;
        burst_end = 1'b0;
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (req0 && req1) state_nxt = last ? GNT0 : GNT1;
                else if (req0)    state_nxt = GNT0;
                else if (req1)    state_nxt = GNT1;
            end
            GNT0: begin
                burst_end = !req0 || (beat == BEAT_MAX);
                if (burst_end) begin
                    last_nxt = 1'b0;
                    if (req1)      state_nxt = GNT1;
                    else if (req0) state_nxt = GNT0;
                    else           state_nxt = IDLE;
                end
            end
            GNT1: begin
                burst_end = !req1 || (beat == BEAT_MAX);
                if (burst_end) begin
                    last_nxt = 1'b1;
                    if (req0)      state_nxt = GNT0;
                    else if (req1) state_nxt = GNT1;
                    else           state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A same-requester re-grant still starts a fresh burst count.
        if (burst_end || (state_nxt != state)) beat_nxt = '0;
        else if (beat0 || beat1)               beat_nxt = beat + 3'd1;
        else                                   beat_nxt = beat;
    end

    always_comb begin
        gnt0   = (state == GNT0);
        gnt1   = (state == GNT1);
        mem_en = beat0 || beat1;
        mem_W  = '0;
        mem_J  = '0;
        if (beat0) begin
            mem_W = W0;
            mem_J = J0;
        end else if (beat1) begin
            mem_W = W1;
            mem_J = J1;
        end
        Cost0 = mem_Cost & {CW{cvld0}};
        Cost1 = mem_Cost & {CW{cvld1}};
    end

endmodule

// File: tb/tb_jam_cost_arbiter.sv
// Directed bench for jam_cost_arbiter: BURST_LEN=8 and BURST_LEN=1 instances, cost scoreboard per requester.
module tb_jam_cost_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r0 [2];
    logic       r1 [2];
    logic [2:0] w0 [2];
    logic [2:0] j0 [2];
    logic [2:0] w1 [2];
    logic [2:0] j1 [2];
    logic       g0 [2];
    logic       g1 [2];
    logic       cv0 [2];
    logic       cv1 [2];
    logic       men [2];
    logic [2:0] mw [2];
    logic [2:0] mj [2];
    logic [6:0] c0 [2];
    logic [6:0] c1 [2];
    logic [6:0] mc [2];

    int unsigned nvec = 0;
    int unsigned nerr = 0;
    logic [2:0]  n0, n1;
    logic        pv0, pv1;
    logic [6:0]  q0 [$];
    logic [6:0] q1 [$];

    always #5 clk = ~clk;

    jam_cost_arbiter #(.BURST_LEN(8), .CW(7)) u_bl8 (
        .CLK(clk), .RST_N(rst_n),
        .req0(r0[0]), .req1(r1[0]), .W0(w0[0]), .W1(w1[0]), .J0(j0[0]), .J1(j1[0]),
        .gnt0(g0[0]), .gnt1(g1[0]), .Cost0(c0[0]), .Cost1(c1[0]),
        .cvld0(cv0[0]), .cvld1(cv1[0]),
        .mem_en(men[0]), .mem_W(mw[0]), .mem_J(mj[0]), .mem_Cost(mc[0])
    );

    jam_cost_arbiter #(.BURST_LEN(1), .CW(7)) u_bl1 (
        .CLK(clk), .RST_N(rst_n),
        .req0(r0[1]), .req1(r1[1]), .W0(w0[1]), .W1(w1[1]), .J0(j0[1]), .J1(j1[1]),
        .gnt0(g0[1]), .gnt1(g1[1]), .Cost0(c0[1]), .Cost1(c1[1]),
        .cvld0(cv0[1]), .cvld1(cv1[1]),
        .mem_en(men[1]), .mem_W(mw[1]), .mem_J(mj[1]), .mem_Cost(mc[1])
    );

    // Cost memory model: Cost = 8*W + J, one-cycle read latency.
    for (genvar d = 0; d < 2; d++) begin : g_mem
        always_ff @(posedge clk) begin
            if (men[d]) mc[d] <= {1'b0, mw[d], mj[d]};
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input int d);
        chk("rst_gnt0", 8'(g0[d]), 8'd0);
        chk("rst_gnt1", 8'(g1[d]), 8'd0);
        chk("rst_cvld0", 8'(cv0[d]), 8'd0);
        chk("rst_cvld1", 8'(cv1[d]), 8'd0);
        chk("rst_cost0", 8'(c0[d]), 8'd0);
        chk("rst_cost1", 8'(c1[d]), 8'd0);
        chk("rst_mem_en", 8'(men[d]), 8'd0);
        chk("rst_mem_W", 8'(mw[d]), 8'd0);
        chk("rst_mem_J", 8'(mj[d]), 8'd0);
    endtask

    task automatic begin_test();
        n0  = '0;
        n1  = '0;
        pv0 = 1'b0;
        pv1 = 1'b0;
    endtask

    // One clock cycle: drive requests, check grant/response/memory port, push expected costs.
    task automatic step(input int d, input logic a0, input logic a1,
                        input logic eg0, input logic eg1);
        logic       b0, b1;
        logic [6:0] e0, e1;
        logic [2:0] ew, ej;
        r0[d] = a0;
        r1[d] = a1;
        w0[d] = n0;
        j0[d] = 3'd7 - n0;
        w1[d] = n1;
        j1[d] = n1 ^ 3'd5;
        b0 = eg0 & a0;
        b1 = eg1 & a1;
        #1;
        chk("gnt0", 8'(g0[d]), 8'(eg0));
        chk("gnt1", 8'(g1[d]), 8'(eg1));
        chk("cvld0", 8'(cv0[d]), 8'(pv0));
        chk("cvld1", 8'(cv1[d]), 8'(pv1));
        e0 = '0;
        e1 = '0;
        if (cv0[d] && q0.size() > 0) e0 = q0.pop_front();
        if (cv1[d] && q1.size() > 0) e1 = q1.pop_front();
        chk("cost0", 8'(c0[d]), 8'(e0));
        chk("cost1", 8'(c1[d]), 8'(e1));
        ew = '0;
        ej = '0;
        if (b0) begin
            ew = n0;
            ej = 3'd7 - n0;
        end else if (b1) begin
            ew = n1;
            ej = n1 ^ 3'd5;
        end
        chk("mem_en", 8'(men[d]), 8'(b0 | b1));
        chk("mem_W", 8'(mw[d]), 8'(ew));
        chk("mem_J", 8'(mj[d]), 8'(ej));
        if (b0) begin
            q0.push_back({1'b0, n0, 3'd7 - n0});
            n0++;
        end
        if (b1) begin
            q1.push_back({1'b0, n1, n1 ^ 3'd5});
            n1++;
        end
        pv0 = b0;
        pv1 = b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drained(input string tag);
        chk(tag, 8'(q0.size() + q1.size()), 8'd0);
    endtask

    // Both requesters held for n cycles then dropped together; requester 0 expected first.
    task automatic contend(input int d, input int bl, input int n);
        int g;
        logic rq;
        step(d, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= n; k++) begin
            g  = ((k - 1) / bl) % 2;
            rq = (k < n);
            step(d, rq, rq, g == 0, g == 1);
        end
        step(d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            r0[d] = 1'b0; r1[d] = 1'b0;
            w0[d] = '0;   j0[d] = '0;
            w1[d] = '0;   j1[d] = '0;
        end
        begin_test();
        #2;
        check_zero(0);
        check_zero(1);
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) step(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Contention, 40 cycles: 8/8 alternation starting with requester 0.
        begin_test();
        contend(0, 8, 40);
        drained("contend40_drain");

        // Single burst: W=i, J=7-i, costs 7,14,...,56.
        begin_test();
        step(0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (8) step(0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);
        drained("single_drain");

        // Reset in the middle of a burst: outputs clear at once, in-flight response lost.
        begin_test();
        step(0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(0, 1'b1, 1'b0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        r0[0] = 1'b0;
        #1;
        check_zero(0);
        q0.delete();
        q1.delete();
        begin_test();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) step(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Tie after reset goes to requester 0 with a full-length first burst.
        begin_test();
        contend(0, 8, 10);
        drained("post_reset_drain");

        // Back-to-back bursts from requester 1 alone: 20 beats, no gap.
        begin_test();
        step(0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (20) step(0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b_beats", 8'(n1), 8'(20 % 8));
        drained("b2b_drain");

        // Early drop: requester 0 leaves after 3 beats, one dead cycle, then requester 1.
        begin_test();
        step(0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (8) step(0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("drop_beats0", 8'(n0), 8'd3);
        drained("drop_drain");

        // BURST_LEN=1: grant alternates every cycle.
        begin_test();
        contend(1, 1, 8);
        drained("bl1_drain");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/jam_cost_arbiter.md
# jam_cost_arbiter

Round-robin arbiter that shares one synchronous job-cost memory between two job-assignment search engines. Each engine reads the memory in bursts of consecutive (worker, job) lookups, one full permutation per burst. The arbiter locks the grant for up to BURST_LEN accepted reads so that a permutation's cost sum is never interleaved. It sits between the two engines and the cost memory, and is the only master of the memory port.

## Interface
- BURST_LEN, 8: maximum accepted reads per grant before re-arbitration; legal range 1..8.
- CW, 7: cost data width.

- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  requester wants a read this cycle; the requester holds W/J stable while req is high and gnt is low.
- W0 / W1  in  3  worker index of the read.
- J0 / J1  in  3  job index of the read.
- gnt0 / gnt1  out  1  registered grant; at most one is high.
- Cost0 / Cost1  out  CW  returned cost; equals mem_Cost when the matching cvld is high, else 0.
- cvld0 / cvld1  out  1  Cost is valid for the read accepted in the previous cycle.
- mem_en  out  1  memory read strobe.
- mem_W / mem_J  out  3  memory address; the granted requester's W/J when mem_en=1, else 0.
- mem_Cost  in  CW  memory data; valid the cycle after mem_en.

## Operation
- States: IDLE, GNT0, GNT1. gntX = (state == GNTX).
- Accepted read (beat): a cycle with gntX=1 and reqX=1.
  - On a beat: mem_en=1 and mem_W/mem_J = WX/JX (combinational).
  - cvldX is registered high for the next cycle.
- Beat counter `beat` is 3 bits. It increments on each beat and resets to 0 at burst end and on any state change.
- Burst end occurs in cycle t when either:
  - the beat in cycle t is beat number BURST_LEN (beat == BURST_LEN-1), or
  - gntX=1 and reqX=0 (the requester dropped; no access in that cycle).
- Last-served pointer `last`:
  - updated to X at the end of a GNTX burst;
  - reset value 1, so requester 0 wins the first tie.
- IDLE next state:
  - only one req is high: grant that requester;
  - both are high: grant requester !last;
  - neither is high: stay in IDLE.
- GNTX at burst end, next state:
  - other requester's req is high: GNT(other);
  - else reqX is high: GNTX with a new burst and no bubble;
  - else IDLE.
- GNTX without burst end: stay in GNTX.
- Responses: CostX = mem_Cost & {CW{cvldX}}. The arbiter does not register data.
- No starvation: with both requesters continuously active, grants alternate every BURST_LEN beats.

## Timing
- Reset values:
  - state IDLE, last=1, beat=0;
  - gnt0=gnt1=0, cvld0=cvld1=0, Cost0=Cost1=0;
  - mem_en=0, mem_W=mem_J=0.
- Reset takes effect asynchronously and aborts any burst. A response in flight is discarded: cvld is cleared and is not reasserted after release.
- Request-to-grant latency: reqX rising in cycle t from IDLE gives gntX=1 in cycle t+1, the first beat in t+1, and cvldX/CostX in t+2.
- Read latency: a beat in cycle t gives cvldX=1 in cycle t+1.
- Burst switch has zero bubble. The last beat of requester 0 is in cycle t; gnt1=1 and the first beat of requester 1 are in cycle t+1. cvld0 (t+1) and cvld1 (t+2) never overlap.
- Requester drop costs one dead cycle: gntX stays high for the drop cycle, then moves on.
- BURST_LEN=1 with both requesting: grant alternates every cycle.
- gnt depends only on registered state. mem_en/mem_W/mem_J depend combinationally on reqX of the granted requester.

## Test plan
- Reset: drive RST_N=0 mid-run.
  - All outputs go to 0 immediately.
  - After release with req0=req1=0, everything stays 0 and the state is IDLE.
- Single burst: memory model Cost = 8*W + J; req0 high with W0 = 0..7 and J0 = 7-W0 over 8 beats.
  - gnt0 rises one cycle after req0.
  - cvld0 is high for 8 consecutive cycles with Cost0 = 7, 14, 21, 28, 35, 42, 49, 56.
- Contention: req0 and req1 held high for 40 cycles, BURST_LEN=8.
  - gnt0 for 8 cycles, then gnt1 for 8, alternating.
  - No cycle with both gnt high; no bubble cycles after the first grant.
  - Requester 0 is granted first.
- Back-to-back single requester: req1 only, for 20 cycles.
  - gnt1 is continuous from the cycle after req1.
  - 20 cvld1 pulses; beat wraps at 8 and 16 with no gap.
- Early drop: req1 held high; req0 drops after 3 beats.
  - gnt0 lasts 4 cycles (3 beats plus the drop cycle); gnt1 asserts the next cycle.
  - cvld0 pulses exactly 3 times.
- BURST_LEN=1 with both requesting continuously: gnt0/gnt1 toggle every cycle, and mem_W follows W0, W1, W0, ...
